// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream and instruction-memory write bundle for imem_loader.
//   in_valid  : byte present on in_data            (host -> loader)
//   in_data   : stream byte                        (host -> loader)
//   in_ready  : loader accepts a byte this cycle   (loader -> host)
//   mem_we    : instruction-memory write strobe    (loader -> memory)
//   mem_addr  : word address of the write          (loader -> memory)
//   mem_wdata : 32-bit instruction word            (loader -> memory)
// Modports: master = host/memory side, slave = loader side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
// Frame: 16-bit big-endian word count N, then N big-endian 32-bit words,
// written to word addresses 0..N-1. Holds the processor in reset until done.
// Ports:
//   clk     : clock, all state changes on posedge
//   rst     : synchronous active-low reset
//   bus     : imem_loader_if.slave (byte stream in, memory write port out)
//   reload  : single-cycle pulse, restarts loading when in DONE
//   cpu_rst : processor reset, active-high, 1 while not in DONE
//   done    : image loaded, processor running
//   err     : sticky frame error (header count exceeds memory capacity,
//             or checksum mismatch when enabled)
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// XOR-of-data-bytes checksum byte before DONE.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus,
  input  logic          reload,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = DONE;
`endif

  state_t            state_q, state_d;

  logic              in_ready_q, in_ready_d;
  logic              cpu_rst_d, done_d, err_d;

  logic [7:0]        hdr_hi_q;
  logic [ADDR_W:0]   n_words_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W:0]   word_cnt_inc;
  logic [1:0]        byte_idx_q;
  logic [23:0]       asm_q;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  logic              xfer;
  logic [15:0]       n_full;
  logic              hdr_over;
  logic              last_word;

  assign xfer         = bus.in_valid & in_ready_q;
  assign n_full       = {hdr_hi_q, bus.in_data};
  // Counts above 2**ADDR_W cannot fit; with ADDR_W >= 16 every count fits.
  assign hdr_over     = (ADDR_W < 16) && ({16'h0000, n_full} > (32'd1 << ADDR_W));
  assign word_cnt_inc = word_cnt_q + 1'b1;
  assign last_word    = (word_cnt_inc == n_words_q);

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HDR_HI;
      in_ready_q <= 1'b1;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      cpu_rst    <= cpu_rst_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_HI: if (xfer) state_d = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (n_full == 16'h0000)  state_d = END_STATE;
          else if (hdr_over)       state_d = ERR;
          else                     state_d = DATA;
        end
      end
      DATA: if (xfer && (byte_idx_q == 2'd3) && last_word) state_d = END_STATE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (xfer) state_d = (bus.in_data == chk_q) ? DONE : ERR;
`endif
      DONE: if (reload) state_d = HDR_HI;
      ERR:  state_d = ERR;
      default: state_d = HDR_HI;
    endcase
  end

  // Output decode, registered above. Leaving DATA straight into DONE holds
  // done/cpu_rst back one cycle so the final write strobe lands first.
  always_comb begin
    in_ready_d = state_d inside {HDR_HI, HDR_LO, DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
                                 , CHK
`endif
                                 };
    done_d     = (state_d == DONE) && (state_q != DATA);
    cpu_rst_d  = !done_d;
    err_d      = (state_d == ERR);
  end

  // Header capture, word assembly and memory write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      hdr_hi_q    <= '0;
      n_words_q   <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          HDR_HI: hdr_hi_q <= bus.in_data;
          HDR_LO: begin
            n_words_q  <= (ADDR_W+1)'(n_full);
            word_cnt_q <= '0;
            byte_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
          end
          DATA: begin
            asm_q      <= {asm_q[15:0], bus.in_data};
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_q ^ bus.in_data;
`endif
            if (byte_idx_q == 2'd3) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              mem_wdata_q <= {asm_q, bus.in_data};
              word_cnt_q  <= word_cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader: the write side of the processor's instruction memory, which the fetch stage only ever reads. It receives a framed byte stream over a valid/ready handshake. It assembles big-endian 32-bit instruction words, writes them to consecutive word addresses from 0, and holds the processor in reset until the image is complete. It sits between the host byte link and the instruction-memory write port, and it drives the processor's active-high reset.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
- reload  in  1  single-cycle pulse; honoured only in DONE.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  instruction word.
- cpu_rst  out  1  processor reset, active-high; 1 while not in DONE.
- done  out  1  image loaded, processor running.
- err  out  1  sticky frame error.

## Operation
- Frame format: header N (16-bit, big-endian, 2 bytes), then N words of 4 bytes each, big-endian (first byte → bits 31:24).
- States are HDR_HI, HDR_LO, DATA, DONE and ERR. Reset enters HDR_HI.
- HDR_HI: accept byte → N[15:8]; go to HDR_LO.
- HDR_LO: accept byte → N[7:0].
  - If N == 0: go to DONE.
  - If N > 2**ADDR_W: go to ERR.
  - Otherwise: go to DATA with word counter = 0 and byte index = 0.
- DATA:
  - Each accepted byte shifts into a 32-bit assembly register.
  - The 2-bit byte index wraps 3 → 0.
  - On the 4th byte, issue a write to address = word counter, then increment the counter.
  - After word N−1 is written, go to DONE.
- DONE: in_ready = 0 and done = 1. A reload pulse goes to HDR_HI; cpu_rst reasserts on the next cycle.
- ERR: in_ready = 0, err = 1, cpu_rst = 1. Only rst exits this state.
- in_ready = 1 in HDR_HI, HDR_LO and DATA. Bytes may arrive back-to-back, one per cycle, with no stall for memory writes.
- Bytes offered while in_ready = 0 are not consumed. Gaps (in_valid = 0) are allowed anywhere and do not change state.
- reload outside DONE is ignored.
- The word counter is ADDR_W+1 bits wide. N = 2**ADDR_W fills memory exactly, with the last address = 2**ADDR_W − 1.
- rst asserted mid-frame discards the partial word and header and returns to HDR_HI. No write is issued for the partial word.

## Timing
- Reset values: in_ready = 1 (entering HDR_HI), mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_rst = 1, done = 0, err = 0.
- All outputs are registered.
- Write latency: when the 4th byte of a word is accepted at edge k, mem_we = 1 with valid mem_addr and mem_wdata during the cycle after edge k.
  - The strobe lasts exactly one cycle.
  - mem_addr and mem_wdata hold their last values afterwards.
- Completion: after the final write strobe, done = 1 and cpu_rst = 0 from the next edge. The processor's first fetch therefore sees all words written.
- N == 0: done = 1 and cpu_rst = 0 one cycle after the second header byte is accepted.
- ERR entry: err = 1 one cycle after the offending header byte.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last data byte, the loader enters a CHK state with in_ready = 1 and expects one byte equal to the XOR of all 4N data bytes. The header is excluded, and the XOR is 0x00 when N = 0.
  - Match → DONE. Mismatch → ERR.
  - Because of CHK, done and cpu_rst change one cycle after the checksum byte is accepted, not after the last write.
- Without the macro: there is no CHK state and no checksum byte; the frame ends after the last data word.

## Test plan
- Basic load, back-to-back bytes: 00 02 00 00 00 13 DE AD BE EF.
  - Required: two write strobes, (addr 0, 0x00000013) then (addr 1, 0xDEADBEEF).
  - Required: done = 1 and cpu_rst = 0 the cycle after the second strobe.
  - With IMEM_LOADER_CHECKSUM_EN, append byte 0x13^0xDE^0xAD^0xBE^0xEF.
- Empty image: 00 00.
  - Required: no strobes; done = 1 one cycle after the second byte.
  - With the macro, 00 00 followed by 00 → done.
- Overflow with ADDR_W = 8: header 01 01 (N = 257).
  - Required: err = 1 and in_ready = 0; no strobes; cpu_rst stays 1.
  - Required: further bytes are not consumed.
- Gapped stream with random in_valid bubbles, N = 3.
  - Required: the same writes and addresses as the bubble-free stream.
  - Required: a strobe appears exactly one cycle after each 4th byte is accepted.
- Mid-frame reset: rst = 0 after 6 of 10 bytes, then the full frame is resent.
  - Required: no write for the partial second word; the final memory contents match the full frame.
- Reload: in DONE, pulse reload and send 00 01 11 22 33 44.
  - Required: cpu_rst = 1 during the load, then a write (addr 0, 0x11223344), then done.
  - With the macro, a wrong checksum byte instead gives err = 1 and cpu_rst = 1.
